// File: rtl/demux3_pkg.sv
// demux3_pkg: shared widths, select encodings and FIFO state type for the 3-way demux
package demux3_pkg;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam logic [1:0] SEL_Y0  = 2'd0;
  localparam logic [1:0] SEL_Y1  = 2'd1;
  localparam logic [1:0] SEL_Y2  = 2'd2;
  localparam logic [1:0] SEL_BAD = 2'd3;
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_FULL = 2'd2} fifo_state_e;
endpackage

// File: rtl/demux_fifo2.sv
// demux_fifo2: two-entry valid/ready FIFO; full ignores a same-cycle pop so push acceptance never depends on the consumer
module demux_fifo2
  import demux3_pkg::*;
#(
  parameter int WIDTH = demux3_pkg::WIDTH,
  parameter int DEPTH = demux3_pkg::DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready
);
  localparam int AW = $clog2(DEPTH);
  fifo_state_e state, state_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full    = state == ST_FULL;
  assign valid   = state != ST_EMPTY;
  assign data    = valid ? mem[rd_ptr] : '0;
  assign do_push = push & ~full;
  assign do_pop  = valid & ready;
  always_comb begin
    state_nxt = state;
    state_nxt = (do_push && !do_pop) ? ((state == ST_EMPTY) ? ST_ONE : ST_FULL) :
                (do_pop && !do_push) ? ((state == ST_FULL) ? ST_ONE : ST_EMPTY) : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else state <= state_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/demux3_32_buf.sv
// demux3_32_buf: routes each input word to one of three buffered output ports by in_sel; in_sel = 3 words are dropped and counted
module demux3_32_buf
  import demux3_pkg::*;
#(
  parameter int WIDTH = demux3_pkg::WIDTH,
  parameter int DEPTH = demux3_pkg::DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0_data,
  output logic [WIDTH-1:0] y1_data,
  output logic [WIDTH-1:0] y2_data,
  output logic             y0_valid,
  output logic             y1_valid,
  output logic             y2_valid,
  input  logic             y0_ready,
  input  logic             y1_ready,
  input  logic             y2_ready,
  output logic [7:0]       drop_cnt
);
  logic [3:0] full;
  logic [2:0] push, valid, ready;
  logic [WIDTH-1:0] data [3];
  logic accept;
  assign full[3]  = 1'b0;
  assign in_ready = rst_n & ~full[in_sel];
  assign accept   = in_valid & in_ready;
  assign push     = {in_sel == SEL_Y2, in_sel == SEL_Y1, in_sel == SEL_Y0} & {3{accept}};
  assign ready    = {y2_ready, y1_ready, y0_ready};
  assign {y2_valid, y1_valid, y0_valid} = valid;
  assign y0_data  = data[0];
  assign y1_data  = data[1];
  assign y2_data  = data[2];
  for (genvar i = 0; i < 3; i++) begin : g_port
    demux_fifo2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push[i]),
      .push_data(in_data),
      .full     (full[i]),
      .data     (data[i]),
      .valid    (valid[i]),
      .ready    (ready[i])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt <= '0;
    else if (accept && in_sel == SEL_BAD && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
  end
endmodule

// File: tb/tb_demux3_32_buf.sv
// tb_demux3_32_buf: directed and random stimulus checked against a queue-based model of the three port FIFOs
module tb_demux3_32_buf;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] y0_data, y1_data, y2_data;
  logic        y0_valid, y1_valid, y2_valid;
  logic        yr [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0]  drop_cnt;
  logic [31:0] yd [3];
  logic        yv [3];
  logic [31:0] q [3][$];
  int          drops = 0;
  int          vectors = 0, errors = 0;
  always #5 clk = ~clk;
  demux3_32_buf dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .y0_data(y0_data), .y1_data(y1_data), .y2_data(y2_data),
    .y0_valid(y0_valid), .y1_valid(y1_valid), .y2_valid(y2_valid),
    .y0_ready(yr[0]), .y1_ready(yr[1]), .y2_ready(yr[2]), .drop_cnt(drop_cnt)
  );
  assign yd[0] = y0_data;
  assign yd[1] = y1_data;
  assign yd[2] = y2_data;
  assign yv[0] = y0_valid;
  assign yv[1] = y1_valid;
  assign yv[2] = y2_valid;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic model_ready();
    return rst_n && (in_sel == 2'd3 || q[in_sel].size() < 2);
  endfunction
  task automatic check_all();
    chk("in_ready", in_ready, model_ready());
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("y%0d_valid", p), yv[p], q[p].size() > 0);
      chk($sformatf("y%0d_data", p), yd[p], q[p].size() > 0 ? q[p][0] : 32'd0);
    end
    chk("drop_cnt", drop_cnt, drops);
  endtask
  task automatic cycle();
    logic acc;
    #1;
    check_all();
    acc = in_valid && model_ready();
    @(posedge clk);
    for (int p = 0; p < 3; p++)
      if (yr[p] && q[p].size() > 0) void'(q[p].pop_front());
    if (acc) begin
      if (in_sel == 2'd3) drops = (drops < 255) ? drops + 1 : 255;
      else q[in_sel].push_back(in_data);
    end
    @(negedge clk);
  endtask
  task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask
  task automatic enter_reset();
    rst_n = 1'b0;
    #1;
    for (int p = 0; p < 3; p++) q[p].delete();
    drops = 0;
    check_all();
  endtask
  initial begin
    enter_reset();
    @(negedge clk);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    yr = '{1'b1, 1'b1, 1'b1};
    for (int s = 0; s < 4; s++) begin
      drive(1'b0, s[1:0], 32'd0);
      #1 chk("post_reset_ready", in_ready, 1'b1);
    end
    drive(1'b1, 2'd0, 32'd32767); cycle();
    chk("y0_first", y0_data, 32'd32767);
    drive(1'b1, 2'd1, 32'd16383); cycle();
    chk("y1_first", y1_data, 32'd16383);
    drive(1'b1, 2'd2, 32'd65535); cycle();
    chk("y2_first", y2_data, 32'd65535);
    chk("y2_only_valid", {y0_valid, y1_valid, y2_valid}, 3'b001);
    drive(1'b0, 2'd0, 32'd0); cycle();
    yr[1] = 1'b0;
    drive(1'b1, 2'd1, 32'd1); cycle();
    drive(1'b1, 2'd1, 32'd2); cycle();
    drive(1'b1, 2'd1, 32'd3);
    #1 chk("y1_full_reject", in_ready, 1'b0);
    cycle();
    yr[1] = 1'b1;
    chk("y1_order0", y1_data, 32'd1); cycle();
    chk("y1_order1", y1_data, 32'd2); cycle();
    drive(1'b0, 2'd1, 32'd0);
    chk("y1_order2", y1_data, 32'd3); cycle();
    cycle();
    yr[0] = 1'b0;
    drive(1'b1, 2'd0, 32'hA0); cycle();
    drive(1'b1, 2'd0, 32'hA1); cycle();
    yr[0] = 1'b1;
    drive(1'b1, 2'd0, 32'hA2);
    #1 chk("y0_full_pop_reject", in_ready, 1'b0);
    cycle();
    chk("y0_next_accept", in_ready, 1'b1);
    cycle();
    drive(1'b0, 2'd0, 32'd0); cycle(); cycle();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 2'd3, $urandom);
      #1 chk("bad_ready", in_ready, 1'b1);
      chk("bad_no_valid", {y0_valid, y1_valid, y2_valid}, 3'b000);
      cycle();
    end
    chk("drop_sat", drop_cnt, 8'd255);
    yr[2] = 1'b0;
    drive(1'b1, 2'd2, 32'h11); cycle();
    drive(1'b1, 2'd2, 32'h22); cycle();
    drive(1'b1, 2'd2, 32'h33);
    @(posedge clk);
    #2;
    enter_reset();
    chk("rst_y2_valid", y2_valid, 1'b0);
    chk("rst_drop", drop_cnt, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 2'd2, 32'd0);
    #1 chk("rst_release_ready", in_ready, 1'b1);
    cycle();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 3 ? 2'd3 : 2'($urandom_range(0, 2)), $urandom);
      for (int p = 0; p < 3; p++) yr[p] = $urandom_range(0, 2) != 0;
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/demux3_32_buf.md
DEMUX3_32_BUF -- requirements
Module: demux3_32_buf

Interface
REQ-001 Parameter WIDTH, default 32, data width of input and each output port.
REQ-002 Parameter DEPTH, default 2, entries per output FIFO; only 2 is supported.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_data  input  WIDTH  word to route.
REQ-006 in_sel  input  2  destination: 00 to port Y0, 01 to Y1, 10 to Y2, 11 invalid.
REQ-007 in_valid  input  1  in_data/in_sel are valid.
REQ-008 in_ready  output  1  block accepts the word this cycle.
REQ-009 y0_data, y1_data, y2_data  output  WIDTH each  head of each port FIFO.
REQ-010 y0_valid, y1_valid, y2_valid  output  1 each  port holds a word.
REQ-011 y0_ready, y1_ready, y2_ready  input  1 each  consumer takes the word.
REQ-012 drop_cnt  output  8  count of words dropped because in_sel = 11.

Function
REQ-013 A transfer occurs on any rising clk edge where valid and ready are both high; this applies to the input and to each output.
REQ-014 in_ready SHALL be 1 when in_sel = 11, and otherwise the inverse of the selected FIFO's full flag.
REQ-015 in_ready SHALL NOT depend combinationally on any yN_ready; a full FIFO rejects a push even when it is popped in the same cycle.
REQ-016 An accepted word with in_sel = 0..2 is written to that port's FIFO only; the other ports are unchanged.
REQ-017 Latency: a word accepted at edge k appears on its yN_data with yN_valid = 1 after edge k; there is no combinational bypass.
REQ-018 Each port is FIFO-ordered; words to different ports are independent and can be reordered relative to each other.
REQ-019 yN_valid and yN_data are stable while yN_valid = 1 and yN_ready = 0.
REQ-020 A simultaneous push and pop on a non-full, non-empty FIFO leaves its occupancy unchanged.
REQ-021 A simultaneous push and pop on a FIFO holding 1 entry advances the head to the new word.
REQ-022 FIFO states: EMPTY (0 entries), ONE (1 entry), FULL (2 entries).
REQ-023 FIFO transitions: push moves EMPTY to ONE and ONE to FULL; pop moves FULL to ONE and ONE to EMPTY; push with pop holds the state.
REQ-024 Write and read pointers are 1 bit each and wrap modulo 2.
REQ-025 An accepted word with in_sel = 11 is discarded, and drop_cnt increments by 1, saturating at 255.
REQ-026 yN_data equals 0 whenever yN_valid = 0.

Reset
REQ-027 While rst_n = 0: all FIFOs EMPTY, yN_valid = 0, yN_data = 0, drop_cnt = 0, in_ready = 0.
REQ-028 Reset during operation discards all buffered words immediately; no partial transfer completes on the edge where rst_n is low.
REQ-029 On the first edge after rst_n rises, in_ready = 1 for any in_sel.

Structure
REQ-030 Shared package demux3_pkg SHALL hold WIDTH, DEPTH, the select encodings SEL_Y0/SEL_Y1/SEL_Y2/SEL_BAD, and the FIFO state typedef.
REQ-031 Sub-module demux_fifo2 (2-entry FIFO with valid/ready, async active-low reset) SHALL be instantiated three times; top-level routing and drop counting are in demux3_32_buf.

Verification
REQ-032 Send in_data = 32767 with sel 00, then 16383 with sel 01, then 65535 with sel 10, all yN_ready = 1 -> each value appears on y0/y1/y2 respectively one cycle after acceptance; other ports have valid = 0.
REQ-033 Hold y1_ready = 0 and send 1, 2, 3 to sel 01 -> 1 and 2 accepted; in_ready = 0 on the third; raise y1_ready -> outputs 1, 2, 3 in order.
REQ-034 y0 FULL with y0_ready = 1 and push to sel 00 -> push rejected that cycle; accepted on the next cycle.
REQ-035 Send 300 words with sel 11 -> in_ready is always 1, no yN_valid rises, drop_cnt saturates at 255.
REQ-036 Fill y2 with 2 words, pulse rst_n low mid-cycle -> y2_valid = 0 and drop_cnt = 0 immediately; after release, in_ready = 1 and FIFOs are empty.
